// File: rtl/z88_ps2_pkg.sv
// z88_ps2_pkg: shared PS/2 state encoding, default timing and parity helper
// Rev 1.0 - initial release
`default_nettype none

package z88_ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_e;

  // 100 us inhibit and 15 ms edge timeout at a 20 MHz system clock
  localparam int unsigned PS2_INHIBIT_CYC = 2000;
  localparam int unsigned PS2_TIMEOUT_CYC = 300000;

  function automatic logic odd_parity(input logic [7:0] i_d);
    return ~^i_d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_sync.sv
// ps2_sync: 2-flop synchronizer for the PS/2 lines plus clock falling-edge detect
// Rev 1.0 - initial release
`default_nettype none

module ps2_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic i_ps2clk,
  input  logic i_ps2dat,
  output logic o_clk,
  output logic o_dat,
  output logic o_fall
);

  logic [1:0] r_clk_sync;
  logic [1:0] r_dat_sync;
  logic       r_clk_prev;

  // Idle bus level is high, so flops reset to 1 to avoid a spurious edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_ps2clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2dat};
      r_clk_prev <= r_clk_sync[1];
    end
  end

  assign o_clk  = r_clk_sync[1];
  assign o_dat  = r_dat_sync[1];
  assign o_fall = r_clk_prev & ~r_clk_sync[1];

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (inhibit, start, 8 data, odd parity, stop, ack)
// Rev 1.0 - initial release
`default_nettype none

module ps2_host_tx
  import z88_ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYC = PS2_INHIBIT_CYC,
  parameter int unsigned TIMEOUT_CYC = PS2_TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2clk,
  input  logic       ps2dat,
  output logic       ps2clk_oe,
  output logic       ps2dat_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  ps2_state_e       r_state, w_state;
  logic [7:0]       r_data, w_data;
  logic             r_parity, w_parity;
  logic [3:0]       r_bit, w_bit;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_dat_oe, w_dat_oe;
  logic             r_done, w_done;
  logic             r_err, w_err;

  logic w_clk_s, w_dat_s, w_fall, w_tmo;

  ps2_sync u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_ps2clk (ps2clk),
    .i_ps2dat (ps2dat),
    .o_clk    (w_clk_s),
    .o_dat    (w_dat_s),
    .o_fall   (w_fall)
  );

  assign w_tmo = ((r_state == SEND) || (r_state == ACK) || (r_state == WAIT_IDLE))
               && !w_fall && (r_cnt == TMO_LAST);

  always_comb begin
    w_state  = r_state;
    w_data   = r_data;
    w_parity = r_parity;
    w_bit    = r_bit;
    w_cnt    = r_cnt;
    w_dat_oe = r_dat_oe;
    w_done   = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      IDLE: begin
        if (tx_valid) begin
          w_data   = tx_data;
          w_parity = odd_parity(tx_data);
          w_cnt    = '0;
          w_state  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (r_cnt == INH_LAST) begin
          w_dat_oe = 1'b1;
          w_state  = START;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      START: begin
        w_cnt   = '0;
        w_bit   = '0;
        w_state = SEND;
      end
      SEND: begin
        if (w_fall) begin
          // r_bit is the number of edges already seen, i.e. the data bit to present now
          w_cnt = '0;
          w_bit = r_bit + 4'd1;
          if (r_bit < 4'd8) begin
            w_dat_oe = ~r_data[r_bit[2:0]];
          end else if (r_bit == 4'd8) begin
            w_dat_oe = ~r_parity;
          end else begin
            w_dat_oe = 1'b0;
            w_state  = ACK;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      ACK: begin
        if (w_fall) begin
          w_cnt = '0;
          if (!w_dat_s) begin
            w_state = WAIT_IDLE;
          end else begin
            w_err   = 1'b1;
            w_bit   = '0;
            w_state = IDLE;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (w_clk_s && w_dat_s) begin
          w_done  = 1'b1;
          w_bit   = '0;
          w_state = IDLE;
        end else if (w_fall) begin
          w_cnt = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
    if (w_tmo) begin
      w_done   = 1'b0;
      w_err    = 1'b1;
      w_dat_oe = 1'b0;
      w_bit    = '0;
      w_state  = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_data   <= '0;
      r_parity <= 1'b0;
      r_bit    <= '0;
      r_cnt    <= '0;
      r_dat_oe <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_data   <= w_data;
      r_parity <= w_parity;
      r_bit    <= w_bit;
      r_cnt    <= w_cnt;
      r_dat_oe <= w_dat_oe;
      r_done   <= w_done;
      r_err    <= w_err;
    end
  end

  assign tx_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign ps2clk_oe = (r_state == INHIBIT) || (r_state == START);
  assign ps2dat_oe = r_dat_oe;
  assign done      = r_done;
  assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench with an open-drain PS/2 device model
// Rev 1.0 - initial release
`default_nettype none

module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 1000;
  localparam int H   = 25;   // device half clock period in system clocks (scaled-down 10 kHz)

  typedef struct {
    logic [7:0] data;
    int         mode;      // 0 = device ACKs, 1 = device NACKs
    int         exp_done;
    int         exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2clk_oe, ps2dat_oe, busy, done, err;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2clk, ps2dat;

  assign ps2clk = dev_clk & ~ps2clk_oe;
  assign ps2dat = dev_dat & ~ps2dat_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .ps2clk    (ps2clk),
    .ps2dat    (ps2dat),
    .ps2clk_oe (ps2clk_oe),
    .ps2dat_oe (ps2dat_oe),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected line level at the device's k-th rising edge (1..10)
  function automatic int model_bit(input int data, input int k);
    int ones = 0;
    if (k <= 8) return (data >> (k - 1)) & 1;
    if (k == 10) return 1;
    for (int i = 0; i < 8; i++) ones += (data >> i) & 1;
    return ((ones % 2) == 0) ? 1 : 0;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc++;

  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int err_cyc = 0, err_oe = 0, send_cyc = 0;
  int inh_run = 0, inh_len = 0;
  logic prev_coe = 1'b0;
  int acc_q[$];
  int acc_cyc_q[$];
  int done_cyc_q[$];

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc_q.push_back(cyc);
    end
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
      err_oe  = {ps2clk_oe, ps2dat_oe};
    end
    if (done && err) both_cnt++;
    if (tx_valid && tx_ready && reset_n) begin
      acc_q.push_back(tx_data);
      acc_cyc_q.push_back(cyc);
    end
    if (ps2clk_oe && !ps2dat_oe) inh_run++;
    else if (inh_run != 0) begin
      inh_len = inh_run;
      inh_run = 0;
    end
    if (prev_coe && !ps2clk_oe && busy) send_cyc = cyc;
    prev_coe = ps2clk_oe;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    int t = 0;
    while (!tx_ready && t < 5000) begin tick(); t++; end
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  // mode 0 = ACK, 1 = NACK, 2 = never clocks; abort_after>0 stops after that falling edge
  task automatic device(input int mode, input int abort_after, output logic [9:0] cap, output int nfall);
    int t = 0;
    cap = '0;
    nfall = 0;
    while (!(busy && !ps2clk_oe && ps2dat_oe) && t < 5000) begin tick(); t++; end
    check("host_release", int'(t < 5000), 1);
    if (t >= 5000 || mode == 2) return;
    repeat (H) tick();
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      nfall = k;
      repeat (H) tick();
      if (k == abort_after) return;
      dev_clk = 1'b1;
      cap[k-1] = ps2dat;
      repeat (H) tick();
    end
    if (mode == 0) dev_dat = 1'b0;
    repeat (H / 2) tick();
    dev_clk = 1'b0;
    repeat (H) tick();
    dev_clk = 1'b1;
    repeat (H) tick();
    dev_dat = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int t = 0;
    while (busy && t < budget) begin tick(); t++; end
    check(name, int'(busy), 0);
    repeat (2) tick();
  endtask

  task automatic run_vec(input vec_t v);
    logic [9:0] cap;
    int nf, d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      send_byte(v.data);
      device(v.mode, 0, cap, nf);
    join
    wait_idle("xfer_idle", 500);
    for (int k = 1; k <= 10; k++)
      check($sformatf("line_bit%0d_data%02h", k, v.data), int'(cap[k-1]), model_bit(v.data, k));
    check($sformatf("done_pulses_%02h", v.data), done_cnt - d0, v.exp_done);
    check($sformatf("err_pulses_%02h", v.data), err_cnt - e0, v.exp_err);
    check("inhibit_len", inh_len, INH);
    check("tx_ready_back", int'(tx_ready), 1);
    check("done_err_overlap", both_cnt, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    logic [9:0] cap1, cap2;
    int nf, d0, e0, a0, t;

    repeat (3) tick();
    check("rst_tx_ready", int'(tx_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_clk_oe", int'(ps2clk_oe), 0);
    check("rst_dat_oe", int'(ps2dat_oe), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    reset_n = 1'b1;
    repeat (3) tick();

    vecs[0] = '{8'hED, 0, 1, 0};
    vecs[1] = '{8'hF4, 0, 1, 0};
    vecs[2] = '{8'h3C, 1, 0, 1};
    for (int i = 3; i < 9; i++) begin
      vecs[i].data     = 8'($urandom_range(0, 255));
      vecs[i].mode     = ($urandom_range(0, 3) == 0) ? 1 : 0;
      vecs[i].exp_done = (vecs[i].mode == 0) ? 1 : 0;
      vecs[i].exp_err  = (vecs[i].mode == 0) ? 0 : 1;
    end
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // device never clocks after release
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      send_byte(8'h5A);
      device(2, 0, cap1, nf);
    join
    wait_idle("tmo_idle", 3000);
    check("tmo_latency", err_cyc - send_cyc, TMO);
    check("tmo_err", err_cnt - e0, 1);
    check("tmo_done", done_cnt - d0, 0);
    check("tmo_oe_at_err", err_oe, 0);

    // reset after the 5th falling edge
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      send_byte(8'hED);
      device(0, 5, cap1, nf);
    join
    check("abort_edges", nf, 5);
    check("abort_dat_oe_before", int'(ps2dat_oe), 1 - model_bit(8'hED, 5));
    reset_n = 1'b0;
    tick();
    check("abort_clk_oe", int'(ps2clk_oe), 0);
    check("abort_dat_oe", int'(ps2dat_oe), 0);
    tick();
    reset_n = 1'b1;
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    repeat (5) tick();
    check("abort_done", done_cnt - d0, 0);
    check("abort_err", err_cnt - e0, 0);
    run_vec('{8'h00, 0, 1, 0});

    // tx_valid held with 0xAA during a 0xED transfer
    d0 = done_cnt;
    a0 = acc_q.size();
    fork
      begin
        tx_data  = 8'hED;
        tx_valid = 1'b1;
        tick();
        tx_data = 8'hAA;
        t = 0;
        while (acc_q.size() < a0 + 2 && t < 3000) begin tick(); t++; end
        tx_valid = 1'b0;
      end
      begin
        device(0, 0, cap1, nf);
        device(0, 0, cap2, nf);
      end
    join
    wait_idle("hold_idle", 500);
    check("hold_accepts", acc_q.size() - a0, 2);
    if (acc_q.size() >= a0 + 2 && done_cyc_q.size() >= d0 + 1) begin
      check("hold_first_byte", acc_q[a0], 8'hED);
      check("hold_second_byte", acc_q[a0+1], 8'hAA);
      check("hold_after_done", int'(acc_cyc_q[a0+1] >= done_cyc_q[d0]), 1);
    end
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("hold_ed_bit%0d", k), int'(cap1[k-1]), model_bit(8'hED, k));
      check($sformatf("hold_aa_bit%0d", k), int'(cap2[k-1]), model_bit(8'hAA, k));
    end
    check("hold_done_pulses", done_cnt - d0, 2);
    check("final_overlap", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have parameter INHIBIT_CYC, default 2000, meaning clk cycles the host holds PS/2 clock low before sending (100 us at 20 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 300000, meaning the maximum clk cycles allowed between device clock falling edges, and from release to the first edge (15 ms at 20 MHz).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port tx_data, input, 8 bits: command byte to send to the keyboard.
REQ-006 The block SHALL have port tx_valid, input, 1 bit: tx_data is valid.
REQ-007 The block SHALL have port tx_ready, output, 1 bit: the block accepts a byte (high only in IDLE).
REQ-008 The block SHALL have ports ps2clk and ps2dat, input, 1 bit each: raw PS/2 line levels, asynchronous to clk.
REQ-009 The block SHALL have ports ps2clk_oe and ps2dat_oe, output, 1 bit each: 1 = drive the line low, 0 = release it (open-drain).
REQ-010 The block SHALL have ports busy, done and err, output, 1 bit each: transfer in progress; one-cycle pulse on acknowledged completion; one-cycle pulse on NACK or timeout.

Function
REQ-011 ps2clk and ps2dat SHALL pass through a 2-flop synchronizer; a falling edge is synced-prev=1 and synced-now=0.
REQ-012 A byte SHALL be accepted when tx_valid & tx_ready at a clk edge: tx_data is latched, parity = odd (XNOR-reduce of the data), and the FSM moves IDLE->INHIBIT.
REQ-013 In INHIBIT, ps2clk_oe=1 and ps2dat_oe=0 for exactly INHIBIT_CYC cycles, then the FSM moves to START.
REQ-014 START SHALL last 1 cycle with ps2clk_oe=1 and ps2dat_oe=1 (start bit 0), then move to SEND with ps2clk_oe=0.
REQ-015 In SEND, on each device clock falling edge the bit index n (0..10) SHALL increment and ps2dat_oe SHALL update:
  - edges 1-8: drive data bit n-1, LSB first, as ps2dat_oe = ~bit
  - edge 9: drive parity
  - edge 10: ps2dat_oe=0 (stop bit, released)
  - then go to ACK
REQ-016 In ACK, at the next falling edge, synced ps2dat=0 SHALL mean ACK and move to WAIT_IDLE; ps2dat=1 SHALL mean NACK: pulse err and move to IDLE.
REQ-017 WAIT_IDLE SHALL wait until synced ps2clk=1 and ps2dat=1, then pulse done and move to IDLE.
REQ-018 The timeout counter SHALL clear on entry to SEND and on every falling edge; in SEND, ACK or WAIT_IDLE, reaching TIMEOUT_CYC SHALL pulse err, release both lines and move to IDLE in the same cycle.
REQ-019 busy SHALL be 1 in every state except IDLE; tx_valid while busy SHALL be ignored and SHALL NOT corrupt the latched byte.
REQ-020 Falling edges seen in IDLE, INHIBIT or START SHALL be ignored.
REQ-021 done and err SHALL never be asserted in the same cycle.

Reset
REQ-022 While reset_n=0 at a clk edge:
  - state=IDLE; ps2clk_oe=0, ps2dat_oe=0, done=0, err=0, busy=0, tx_ready=1
  - bit index and counters cleared; synchronizer flops set to 1
REQ-023 Reset asserted mid-transfer SHALL release both lines at that edge and SHALL NOT produce done or err.

Structure
REQ-024 The state enum (IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE) and the default timing constants SHALL live in shared package z88_ps2_pkg, used with the existing keyboard receiver.
REQ-025 The synchronizer and falling-edge detect SHALL be one sub-module, ps2_sync, reusable by the receiver; everything else stays in ps2_host_tx.

Verification
REQ-026 Send 0xED (INHIBIT_CYC=20) with a device model clocking at 10 kHz that ACKs -> ps2clk_oe low for exactly 20 cycles; data bits sampled on rising edges = 1,0,1,1,0,1,1,1; parity 1; stop 1; one done pulse; tx_ready back to 1.
REQ-027 Send 0xF4 -> parity bit sampled as 0; done pulse.
REQ-028 Device leaves data high at the ACK edge -> err pulse, no done, state IDLE.
REQ-029 Device never clocks after release (TIMEOUT_CYC=1000) -> err exactly 1000 cycles after entering SEND, both oe outputs 0.
REQ-030 Assert reset_n=0 after the 5th falling edge -> both oe outputs 0 on the next edge, no done or err; a following send of 0x00 completes with parity 1.
REQ-031 Hold tx_valid with 0xAA during a 0xED transfer -> 0xED is sent intact, and 0xAA is accepted only after done.
